lstm_weight_loader: RTL and testbench
=====================================

# lstm_weight_loader

Upstream parameter stage for the LSTM layer stack. Accepts a serial ready/valid stream of signed words and distributes them into the per-layer, per-gate weight and bias registers consumed by the stacked LSTM cells. It pulses the matching valid bit for each register as it is written. It also reports load completion and stream-framing errors so that the controller can gate datapath traffic until the parameters are loaded.

## Interface
- LAYERS, 3, number of stacked LSTM layers
- WIDTH, 16, word width (signed two's complement)
- WEIGHTS, 4 (localparam), gates per layer
- TOTAL, LAYERS*WEIGHTS*4 (localparam), words per load pass (48 at defaults)
- CW, $clog2(TOTAL+1) (localparam), counter width
---
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begins a load pass (honoured in IDLE only)
- s_data  in  WIDTH signed  stream word
- s_valid  in  1  s_data valid
- s_last  in  1  marks final word of the pass
- s_ready  out  1  loader accepts a word this cycle
- weight_x  out  [LAYERS*WEIGHTS][WIDTH] signed  input weights
- weight_x_valid  out  LAYERS*WEIGHTS  one-cycle write strobes
- weight_h / weight_h_valid  out  same shapes  recurrent weights and strobes
- bias_x / bias_x_valid  out  same shapes  input biases and strobes
- bias_h / bias_h_valid  out  same shapes  recurrent biases and strobes
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky framing error; cleared by the next accepted start
- count  out  CW  words accepted in the current pass

## Operation
- States: IDLE, LOAD.
- IDLE:
  - s_ready=0.
  - When start=1: count←0, error←0, next state LOAD.
- LOAD:
  - s_ready=1.
  - start is ignored.
- Handshake: a word is accepted when s_valid & s_ready.
- Word placement: accepted word index k=count. Slot j=k>>2 (j = layer*WEIGHTS+gate). Kind = k[1:0]: 0 weight_x, 1 weight_h, 2 bias_x, 3 bias_h.
- On acceptance:
  - Register kind[j] ← s_data, stored unchanged.
  - The matching valid bit is high for exactly the next cycle.
  - count increments.
- Unwritten registers hold their value. At most one valid bit across all four vectors is high in any cycle.
- Early last (s_last=1 with k<TOTAL-1):
  - The word is still written.
  - error←1, next state IDLE, no done.
- Final word (k=TOTAL-1):
  - Word written, next state IDLE, done pulses.
  - If s_last=0 on that word, error←1 is also set (missing last); done still pulses.
- A new pass overwrites registers in order. Registers are not cleared at start.

## Timing
- Reset (rst low, asynchronous): all of the following go to 0 immediately and state goes to IDLE:
  - every weight and bias register and every valid bit
  - s_ready, busy, done, error, count
- Reset mid-pass aborts the pass. The loaded contents are lost (zeros).
- Start latency: start high at edge n → busy=1 and s_ready=1 from cycle n+1.
- Write latency: word accepted at edge n → data register and valid bit visible in cycle n+1.
- Completion: final or early-last word accepted at edge n → in cycle n+1, busy=0, s_ready=0 and done/error updated.
  - The last word's valid strobe appears in that same cycle.
- Back-to-back start: start high in the completion cycle n+1 begins a new pass (LOAD at n+2).
- Throughput: one word per cycle with s_valid held high. Gaps in s_valid stall without side effects.
- The count value in cycle n+1 equals the number of words accepted up to edge n.

## Test plan
- Full load, words 1..48 back-to-back, s_last on the 48th:
  - weight_x[0]=1, weight_h[0]=2, bias_x[0]=3, bias_h[0]=4, bias_h[11]=48.
  - Each of the 48 strobes is seen exactly once.
  - done pulses in the cycle after the 48th word; error=0, count=48.
- Bubbled stream (s_valid toggling 1,0,1,0…) with values 100..147:
  - Identical register contents to a gap-free load of the same values.
  - No strobe during gaps; done in the cycle after the last accepted word.
- Early last on word index 9:
  - Words 0..9 written, and weight_h[2] holds the 10th word.
  - error=1, no done, s_ready=0 thereafter; registers from index 10 onward are unchanged.
- Missing last on word 48:
  - done=1 and error=1 in the same cycle.
  - A following start clears error to 0.
- Reset asserted after 20 words:
  - All outputs read 0 immediately, while rst is still low.
  - After release, IDLE with s_ready=0; s_valid=1 is not accepted until start.
- start pulsed at word 5 of a pass: ignored; count continues 6,7,…; the pass completes normally at 48.

Source files
------------

// File: rtl/lstm_weight_loader_if.sv
// Ready/valid word stream into the LSTM weight loader.
// master drives data/valid/last, slave returns ready.
interface lstm_weight_loader_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/lstm_weight_loader.sv
// Streams signed words into per-layer/per-gate weight+bias regs.
// Ports: clk, rst (async low), start, s (stream), regs+strobes, busy/done/error/count.
module lstm_weight_loader #(
  parameter  int LAYERS  = 3,
  parameter  int WIDTH   = 16,
  localparam int WEIGHTS = 4,
  localparam int N       = LAYERS * WEIGHTS,
  localparam int TOTAL   = N * 4,
  localparam int CW      = $clog2(TOTAL + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  lstm_weight_loader_if.slave     s,
  output logic signed [WIDTH-1:0] weight_x [N],
  output logic [N-1:0]            weight_x_valid,
  output logic signed [WIDTH-1:0] weight_h [N],
  output logic [N-1:0]            weight_h_valid,
  output logic signed [WIDTH-1:0] bias_x [N],
  output logic [N-1:0]            bias_x_valid,
  output logic signed [WIDTH-1:0] bias_h [N],
  output logic [N-1:0]            bias_h_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CW-1:0]           count
);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t state;
  state_t state_nx;

  logic          acc;
  logic          kick;
  logic          fin;
  logic [CW-1:0] slot;
  logic [1:0]    kind;

  assign acc  = s.s_valid & s.s_ready;
  assign kick = (state == IDLE) & start;
  assign fin  = (count == CW'(TOTAL - 1));
  assign slot = count >> 2;
  assign kind = count[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (acc && (s.s_last || fin))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s.s_ready = 1'b0;
    busy      = 1'b0;
    if (state == LOAD) begin
      s.s_ready = 1'b1;
      busy      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        weight_x[i] <= '0;
        weight_h[i] <= '0;
        bias_x[i]   <= '0;
        bias_h[i]   <= '0;
      end
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      count          <= '0;
    end else begin
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      done           <= 1'b0;
      if (kick) begin
        count <= '0;
        error <= 1'b0;
      end
      if (acc) begin
        count <= count + CW'(1);
        done  <= fin;
        // last before the end, or the end without last
        if (s.s_last ^ fin)
          error <= 1'b1;
        for (int i = 0; i < N; i++) begin
          if (slot == CW'(i)) begin
            unique case (1'b1)
              (kind == 2'd0): begin
                weight_x[i]       <= s.s_data;
                weight_x_valid[i] <= 1'b1;
              end
              (kind == 2'd1): begin
                weight_h[i]       <= s.s_data;
                weight_h_valid[i] <= 1'b1;
              end
              (kind == 2'd2): begin
                bias_x[i]       <= s.s_data;
                bias_x_valid[i] <= 1'b1;
              end
              (kind == 2'd3): begin
                bias_h[i]       <= s.s_data;
                bias_h_valid[i] <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lstm_weight_loader.sv
// Directed bench for lstm_weight_loader.
// Tasks per scenario, inline checks, one summary line.
module tb_lstm_weight_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  logic signed [15:0] wx [12];
  logic signed [15:0] wh [12];
  logic signed [15:0] bx [12];
  logic signed [15:0] bh [12];
  logic [11:0] wxv, whv, bxv, bhv;
  logic busy, done, error;
  logic [5:0] count;

  int tests = 0;
  int fails = 0;

  int sx [12];
  int sh [12];
  int sbx [12];
  int sbh [12];
  int multi;
  int dones;

  lstm_weight_loader_if #(.WIDTH(16)) bus ();

  lstm_weight_loader #(.LAYERS(3), .WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s(bus.slave),
    .weight_x(wx),
    .weight_x_valid(wxv),
    .weight_h(wh),
    .weight_h_valid(whv),
    .bias_x(bx),
    .bias_x_valid(bxv),
    .bias_h(bh),
    .bias_h_valid(bhv),
    .busy(busy),
    .done(done),
    .error(error),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 12; i++) begin
      if (wxv[i]) sx[i]++;
      if (whv[i]) sh[i]++;
      if (bxv[i]) sbx[i]++;
      if (bhv[i]) sbh[i]++;
    end
    if ($countones({wxv, whv, bxv, bhv}) > 1) multi++;
    if (done) dones++;
  end

  task automatic clear_mon();
    for (int i = 0; i < 12; i++) begin
      sx[i] = 0; sh[i] = 0; sbx[i] = 0; sbh[i] = 0;
    end
    multi = 0;
    dones = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v, input bit last, input bit gap);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(v);
    bus.s_last  = last;
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (gap) tick();
  endtask

  task automatic test_reset();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", bus.s_ready); end
    tests++; if (done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rst_flags got %b%b exp 00", done, error); end
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    for (int i = 0; i < 12; i++) begin
      tests++; if (wx[i] !== 16'sd0 || bh[i] !== 16'sd0) begin fails++; $display("FAIL rst_reg[%0d] got %0d/%0d exp 0", i, wx[i], bh[i]); end
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle got %b exp 0", busy); end
  endtask

  task automatic test_full_load();
    clear_mon();
    do_start();
    tests++; if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin fails++; $display("FAIL full_busy got %b%b exp 11", busy, bus.s_ready); end
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL full_count0 got %0d exp 0", count); end
    for (int k = 0; k < 48; k++) send(k + 1, k == 47, 1'b0);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL full_done got %b exp 1", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL full_error got %b exp 0", error); end
    tests++; if (count !== 6'd48) begin fails++; $display("FAIL full_count got %0d exp 48", count); end
    tests++; if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin fails++; $display("FAIL full_idle got %b%b exp 00", busy, bus.s_ready); end
    tests++; if (wx[0] !== 16'sd1) begin fails++; $display("FAIL full_wx0 got %0d exp 1", wx[0]); end
    tests++; if (wh[0] !== 16'sd2) begin fails++; $display("FAIL full_wh0 got %0d exp 2", wh[0]); end
    tests++; if (bx[0] !== 16'sd3) begin fails++; $display("FAIL full_bx0 got %0d exp 3", bx[0]); end
    tests++; if (bh[0] !== 16'sd4) begin fails++; $display("FAIL full_bh0 got %0d exp 4", bh[0]); end
    tests++; if (bh[11] !== 16'sd48) begin fails++; $display("FAIL full_bh11 got %0d exp 48", bh[11]); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL full_done_pulse got %b exp 0", done); end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (sx[i] != 1 || sh[i] != 1 || sbx[i] != 1 || sbh[i] != 1) begin
        fails++;
        $display("FAIL full_strobe[%0d] got %0d%0d%0d%0d exp 1111", i, sx[i], sh[i], sbx[i], sbh[i]);
      end
    end
    tests++; if (multi != 0) begin fails++; $display("FAIL full_onehot got %0d exp 0", multi); end
    tests++; if (dones != 1) begin fails++; $display("FAIL full_dones got %0d exp 1", dones); end
  endtask

  task automatic test_bubble();
    clear_mon();
    do_start();
    for (int k = 0; k < 48; k++) send(100 + k, k == 47, k != 47);
    tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL bub_done got %b%b exp 10", done, error); end
    for (int j = 0; j < 12; j++) begin
      tests++;
      if (wx[j] !== 16'(100 + 4*j) || wh[j] !== 16'(101 + 4*j) ||
          bx[j] !== 16'(102 + 4*j) || bh[j] !== 16'(103 + 4*j)) begin
        fails++;
        $display("FAIL bub_reg[%0d] got %0d %0d %0d %0d exp %0d..", j, wx[j], wh[j], bx[j], bh[j], 100 + 4*j);
      end
    end
    tick();
    tests++; if (multi != 0 || dones != 1) begin fails++; $display("FAIL bub_strobes got multi %0d dones %0d exp 0 1", multi, dones); end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (sx[i] != 1 || sh[i] != 1 || sbx[i] != 1 || sbh[i] != 1) begin
        fails++;
        $display("FAIL bub_strobe[%0d] got %0d%0d%0d%0d exp 1111", i, sx[i], sh[i], sbx[i], sbh[i]);
      end
    end
  endtask

  task automatic test_early_last();
    clear_mon();
    do_start();
    for (int k = 0; k < 10; k++) send(200 + k, k == 9, 1'b0);
    tests++; if (error !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL early_flags got %b%b exp 10", error, done); end
    tests++; if (bus.s_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL early_idle got %b%b exp 00", bus.s_ready, busy); end
    tests++; if (wh[2] !== 16'sd209) begin fails++; $display("FAIL early_wh2 got %0d exp 209", wh[2]); end
    tests++; if (wx[0] !== 16'sd200) begin fails++; $display("FAIL early_wx0 got %0d exp 200", wx[0]); end
    tests++; if (count !== 6'd10) begin fails++; $display("FAIL early_count got %0d exp 10", count); end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'sd999;
    repeat (3) tick();
    bus.s_valid = 1'b0;
    tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL early_ready got %b exp 0", bus.s_ready); end
    tests++; if (count !== 6'd10) begin fails++; $display("FAIL early_hold got %0d exp 10", count); end
    tests++; if (bx[2] !== 16'sd110) begin fails++; $display("FAIL early_bx2 got %0d exp 110", bx[2]); end
    tests++; if (bh[11] !== 16'sd147) begin fails++; $display("FAIL early_bh11 got %0d exp 147", bh[11]); end
    tests++; if (dones != 0) begin fails++; $display("FAIL early_dones got %0d exp 0", dones); end
  endtask

  task automatic test_missing_last();
    do_start();
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL miss_clear0 got %b exp 0", error); end
    for (int k = 0; k < 48; k++) send(300 + k, 1'b0, 1'b0);
    tests++; if (done !== 1'b1 || error !== 1'b1) begin fails++; $display("FAIL miss_flags got %b%b exp 11", done, error); end
    tests++; if (bh[11] !== 16'sd347) begin fails++; $display("FAIL miss_bh11 got %0d exp 347", bh[11]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL miss_idle got %b exp 0", busy); end
    do_start();
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL miss_clear got %b exp 0", error); end
  endtask

  task automatic test_start_ignored();
    tests++; if (count !== 6'd0 || busy !== 1'b1) begin fails++; $display("FAIL ign_begin got %0d/%b exp 0/1", count, busy); end
    for (int k = 0; k < 48; k++) begin
      start = (k == 5);
      send(400 + k, k == 47, 1'b0);
      start = 1'b0;
      if (k == 5) begin
        tests++; if (count !== 6'd6) begin fails++; $display("FAIL ign_count6 got %0d exp 6", count); end
      end
      if (k == 6) begin
        tests++; if (count !== 6'd7) begin fails++; $display("FAIL ign_count7 got %0d exp 7", count); end
      end
    end
    tests++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL ign_done got %b%b exp 10", done, error); end
    tests++; if (count !== 6'd48) begin fails++; $display("FAIL ign_count got %0d exp 48", count); end
    tests++; if (wx[1] !== 16'sd404) begin fails++; $display("FAIL ign_wx1 got %0d exp 404", wx[1]); end
  endtask

  task automatic test_back_to_back();
    do_start();
    tests++; if (busy !== 1'b1 || count !== 6'd0) begin fails++; $display("FAIL b2b_start got %b/%0d exp 1/0", busy, count); end
    for (int k = 0; k < 20; k++) send(500 + k, 1'b0, 1'b0);
    tests++; if (count !== 6'd20) begin fails++; $display("FAIL b2b_count got %0d exp 20", count); end
    tests++; if (wx[4] !== 16'sd516) begin fails++; $display("FAIL b2b_wx4 got %0d exp 516", wx[4]); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    tests++; if (count !== 6'd0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_state got %0d/%b exp 0/0", count, busy); end
    tests++; if (bus.s_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL rmid_flags got %b%b%b exp 000", bus.s_ready, done, error); end
    tests++; if (wx[4] !== 16'sd0 || wx[0] !== 16'sd0 || bh[11] !== 16'sd0) begin fails++; $display("FAIL rmid_regs got %0d %0d %0d exp 0", wx[4], wx[0], bh[11]); end
    tests++; if ({wxv, whv, bxv, bhv} !== 48'd0) begin fails++; $display("FAIL rmid_valid got %h exp 0", {wxv, whv, bxv, bhv}); end
    tick();
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'sd7;
    repeat (3) tick();
    tests++; if (bus.s_ready !== 1'b0 || count !== 6'd0) begin fails++; $display("FAIL rmid_idle got %b/%0d exp 0/0", bus.s_ready, count); end
    tests++; if (wx[0] !== 16'sd0) begin fails++; $display("FAIL rmid_noacc got %0d exp 0", wx[0]); end
    do_start();
    tick();
    bus.s_valid = 1'b0;
    tests++; if (count !== 6'd1 || wx[0] !== 16'sd7) begin fails++; $display("FAIL rmid_after got %0d/%0d exp 1/7", count, wx[0]); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    clear_mon();
    test_reset();
    test_full_load();
    test_bubble();
    test_early_last();
    test_missing_last();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
